vram_arbiter: RTL

Arbitrates the single SE-VGA VRAM port between video fetches from the VGA output stage and buffered CPU framebuffer writes. CPU writes, already synchronized into the pixel clock domain, enter a small FIFO. They are committed to VRAM only inside the guaranteed-idle slots of each 8-pixel fetch group, so a video read is never disturbed. The block sits directly downstream of the video output stage's address/read-strobe outputs and drives the VRAM pins.

---
 rtl/sevga_pkg.sv | 30 +++
 rtl/vram_wr_fifo.sv | 70 +++++++
 rtl/vram_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/sevga_pkg.sv
// sevga_pkg: shared types and constants for the SE-VGA VRAM write path.
// Build option SEVGA_WR_HOLD_EN adds a HOLD cycle after the write strobe and
// narrows the start window so the last write cycle still ends before seq 7.
package sevga_pkg;

  localparam int SEVGA_ADDR_W = 15;
  localparam int SEVGA_DATA_W = 8;

  // Bit n set: a write may be started from a cycle whose vidSeq is n.
  localparam logic [7:0] WIN_HOLD   = 8'b1000_1111;  // {7,0,1,2,3}
  localparam logic [7:0] WIN_NOHOLD = 8'b1001_1111;  // {7,0,1,2,3,4}

`ifdef SEVGA_WR_HOLD_EN
  typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_STROBE, WR_HOLD} wr_state_e;
  localparam logic [7:0] START_WIN = WIN_HOLD;
`else
  typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_STROBE} wr_state_e;
  localparam logic [7:0] START_WIN = WIN_NOHOLD;
`endif

  typedef struct packed {
    logic [SEVGA_ADDR_W-1:0] addr;
    logic [SEVGA_DATA_W-1:0] data;
  } wr_entry_t;

  function automatic logic in_start_win(input logic [2:0] seq);
    return START_WIN[seq];
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous FIFO for buffered CPU framebuffer writes.
// A push that arrives while full is dropped and flagged, even if a pop
// happens in the same cycle.
module vram_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         dropped
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && (cnt_q != '0);
  assign dout    = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = (cnt_q == '0);
  assign dropped = push && full_q;

  // Pointer and occupancy update; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == FULL_CNT);
  end

  // Control state; reset discards all entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the SE-VGA VRAM port between video fetches and
// buffered CPU writes. Writes only start inside the idle slots of each
// 8-pixel fetch group so the seq-7 video read is never disturbed.
// Build option SEVGA_WR_HOLD_EN: 3-cycle writes (SETUP/STROBE/HOLD) instead
// of 2-cycle writes (SETUP/STROBE).
module vram_arbiter
  import sevga_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = SEVGA_ADDR_W,
  parameter int DATA_W     = SEVGA_DATA_W
) (
  input  logic              pixClock,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] vidAddr,
  input  logic              nVidOE,
  input  logic [2:0]        vidSeq,
  input  logic              cpuWrReq,
  input  logic [ADDR_W-1:0] cpuWrAddr,
  input  logic [DATA_W-1:0] cpuWrData,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramDout,
  output logic              vramDoutEn,
  output logic              nvramOE,
  output logic              nvramWE,
  output logic              fifoFull,
  output logic              ovfErr,
  output logic              colErr
);

  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                we_n_q, we_n_d;
  logic                dout_en_q, dout_en_d;
  logic                ovf_q, ovf_d;
  logic                col_q, col_d;

  logic [ADDR_W+DATA_W-1:0] fifo_dout;
  logic                fifo_full, fifo_empty, fifo_drop;
  logic                pop, start_ok;

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk     (pixClock),
    .rst_n   (nReset),
    .push    (cpuWrReq),
    .pop     (pop),
    .din     ({cpuWrAddr, cpuWrData}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dropped (fifo_drop)
  );

  assign start_ok = !fifo_empty && in_start_win(vidSeq);

  // State register plus the registered pin/flag outputs.
  always_ff @(posedge pixClock) begin
    if (!nReset) begin
      state_q   <= WR_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      we_n_q    <= 1'b1;
      dout_en_q <= 1'b0;
      ovf_q     <= 1'b0;
      col_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      we_n_q    <= we_n_d;
      dout_en_q <= dout_en_d;
      ovf_q     <= ovf_d;
      col_q     <= col_d;
    end
  end

  // Next-state: a new write may chain directly from the last write cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WR_IDLE:   if (start_ok) state_d = WR_SETUP;
      WR_SETUP:  state_d = WR_STROBE;
`ifdef SEVGA_WR_HOLD_EN
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD:   state_d = start_ok ? WR_SETUP : WR_IDLE;
`else
      WR_STROBE: state_d = start_ok ? WR_SETUP : WR_IDLE;
`endif
      default:   state_d = WR_IDLE;
    endcase
    if (!nReset) state_d = WR_IDLE;
    // Entering SETUP always means a fresh FIFO head was accepted.
    pop = (state_d == WR_SETUP);
  end

  // Outputs: registered ones follow the next state so they line up with it.
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) {wr_addr_d, wr_data_d} = fifo_dout;
    we_n_d    = (state_d != WR_STROBE);
    dout_en_d = (state_d != WR_IDLE);
    ovf_d     = ovf_q | fifo_drop;
    col_d     = col_q | (!nVidOE && (state_q != WR_IDLE));
    vramAddr  = (state_q == WR_IDLE) ? vidAddr : wr_addr_q;
    nvramOE   = (state_q == WR_IDLE) ? nVidOE  : 1'b1;
  end

  assign vramDout   = wr_data_q;
  assign vramDoutEn = dout_en_q;
  assign nvramWE    = we_n_q;
  assign fifoFull   = fifo_full;
  assign ovfErr     = ovf_q;
  assign colErr     = col_q;

endmodule
